// File: rtl/display_scan_ctrl.sv
// Time-multiplexed 4-digit hex display scanner with a frame-synchronous
// shadow register, so a new value never appears partway through a frame.
module display_scan_ctrl #(
  parameter int unsigned DIV = 50000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        load,
  input  logic [15:0] din,
  input  logic        lzb,
  output logic [3:0]  nib,
  output logic [3:0]  an,
  output logic        frame,
  output logic        pend
);

  typedef enum logic {IDLE, SCAN} state_t;

  localparam logic [15:0] LAST = 16'(DIV - 1);

  state_t      state, state_d;
  logic [15:0] cnt, cnt_d;
  logic [1:0]  dig, dig_d;
  logic [15:0] disp, disp_d;
  logic [15:0] sh, sh_d;
  logic        pend_d;
  logic        frame_d;
  logic        tick;
  logic        boundary;

  assign tick     = (cnt == LAST);
  assign boundary = tick && (dig == 2'd3);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      dig   <= '0;
      disp  <= '0;
      sh    <= '0;
      pend  <= 1'b0;
      frame <= 1'b0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      dig   <= dig_d;
      disp  <= disp_d;
      sh    <= sh_d;
      pend  <= pend_d;
      frame <= frame_d;
    end
  end

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    dig_d   = dig;
    disp_d  = disp;
    sh_d    = sh;
    pend_d  = pend;
    frame_d = 1'b0;
    case (state)
      IDLE: begin
        // Nothing is on screen, so a load can go straight to the display.
        if (load) begin
          disp_d = din;
          sh_d   = din;
          pend_d = 1'b0;
        end
        if (en) begin
          state_d = SCAN;
          cnt_d   = '0;
          dig_d   = '0;
        end
      end
      SCAN: begin
        if (!en) begin
          state_d = IDLE;
          cnt_d   = '0;
          dig_d   = '0;
          pend_d  = 1'b0;
          if (load) begin
            disp_d = din;
            sh_d   = din;
          end else if (pend) begin
            disp_d = sh;
          end
        end else begin
          cnt_d = tick ? 16'd0 : cnt + 16'd1;
          if (tick) dig_d = dig + 2'd1;
          // Commit uses the old shadow; a coincident load re-arms pend.
          if (boundary) begin
            frame_d = 1'b1;
            if (pend) disp_d = sh;
            pend_d = 1'b0;
          end
          if (load) begin
            sh_d   = din;
            pend_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  logic [3:0] cur_nib;
  logic       blank;

  always_comb begin
    cur_nib = disp[3:0];
    blank   = 1'b0;
    case (dig)
      2'd0: cur_nib = disp[3:0];
      2'd1: begin
        cur_nib = disp[7:4];
        blank   = lzb && (disp[15:4] == 12'd0);
      end
      2'd2: begin
        cur_nib = disp[11:8];
        blank   = lzb && (disp[15:8] == 8'd0);
      end
      default: begin
        cur_nib = disp[15:12];
        blank   = lzb && (disp[15:12] == 4'd0);
      end
    endcase
  end

  always_comb begin
    nib = 4'b0000;
    an  = 4'b1111;
    if (state == SCAN) begin
      nib = cur_nib;
      if (!blank) an = ~(4'b0001 << dig);
    end
  end

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Bench for display_scan_ctrl: directed scenarios then random traffic,
// checked each cycle against a frame-position model of the display.
module tb_display_scan_ctrl;

  localparam int DIV = 4;
  localparam int FRAME_LEN = 4 * DIV;

  logic        clk;
  logic        rst;
  logic        en;
  logic        load;
  logic [15:0] din;
  logic        lzb;
  logic [3:0]  nib;
  logic [3:0]  an;
  logic        frame;
  logic        pend;

  int total;
  int bad;

  // model: whether scanning, position within the frame, shown/shadow values
  bit          m_scan;
  int          m_pos;
  logic [15:0] m_disp;
  logic [15:0] m_sh;
  bit          m_pend;
  bit          m_frame;

  display_scan_ctrl #(.DIV(DIV)) dut (
    .clk   (clk),
    .rst   (rst),
    .en    (en),
    .load  (load),
    .din   (din),
    .lzb   (lzb),
    .nib   (nib),
    .an    (an),
    .frame (frame),
    .pend  (pend)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_scan  = 0;
    m_pos   = 0;
    m_disp  = '0;
    m_sh    = '0;
    m_pend  = 0;
    m_frame = 0;
  endtask

  task automatic model_edge();
    bit at_end;
    if (rst) begin
      model_reset();
      return;
    end
    m_frame = 0;
    if (!m_scan) begin
      if (load) begin
        m_disp = din;
        m_sh   = din;
        m_pend = 0;
      end
      if (en) begin
        m_scan = 1;
        m_pos  = 0;
      end
    end else if (!en) begin
      if (load) begin
        m_disp = din;
        m_sh   = din;
      end else if (m_pend) begin
        m_disp = m_sh;
      end
      m_pend = 0;
      m_scan = 0;
      m_pos  = 0;
    end else begin
      at_end = (m_pos == FRAME_LEN - 1);
      m_pos  = (m_pos + 1) % FRAME_LEN;
      if (at_end) begin
        m_frame = 1;
        if (m_pend) m_disp = m_sh;
        m_pend = 0;
      end
      if (load) begin
        m_sh   = din;
        m_pend = 1;
      end
    end
  endtask

  function automatic logic [3:0] exp_nib();
    logic [15:0] v;
    if (!m_scan) return 4'h0;
    v = m_disp >> (4 * (m_pos / DIV));
    return v[3:0];
  endfunction

  function automatic logic [3:0] exp_an();
    int d;
    logic [15:0] upper;
    logic [3:0]  one;
    if (!m_scan) return 4'hF;
    d     = m_pos / DIV;
    upper = m_disp >> (4 * d);
    if (lzb && d > 0 && upper == 16'h0) return 4'hF;
    one = 4'b0001 << d;
    return ~one;
  endfunction

  task automatic check_outputs();
    chk("nib", {12'h0, nib}, {12'h0, exp_nib()});
    chk("an", {12'h0, an}, {12'h0, exp_an()});
    chk("frame", {15'h0, frame}, {15'h0, m_frame});
    chk("pend", {15'h0, pend}, {15'h0, m_pend});
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic wait_pos(input int p);
    int n;
    n = 0;
    while (!(m_scan && m_pos == p) && n < 4 * FRAME_LEN) begin
      cycle();
      n++;
    end
    chk("wait_pos_timeout", {15'h0, (n >= 4 * FRAME_LEN)}, 16'h0);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    model_reset();
    rst  = 1'b1;
    en   = 1'b0;
    load = 1'b0;
    din  = '0;
    lzb  = 1'b0;

    // reset values
    repeat (2) cycle();
    chk("rst_an", {12'h0, an}, 16'h000F);
    chk("rst_nib", {12'h0, nib}, 16'h0000);
    rst = 1'b0;
    cycle();

    // load 1234 while idle, then scan
    load = 1'b1;
    din  = 16'h1234;
    cycle();
    load = 1'b0;
    chk("idle_load_pend", {15'h0, pend}, 16'h0);
    en = 1'b1;
    cycle();
    chk("first_digit_an", {12'h0, an}, 16'h000E);
    chk("first_digit_nib", {12'h0, nib}, 16'h0004);
    repeat (40) cycle();

    // mid-frame load waits for the boundary
    wait_pos(DIV + 1);
    load = 1'b1;
    din  = 16'hABCD;
    cycle();
    load = 1'b0;
    chk("abcd_pend", {15'h0, pend}, 16'h1);
    repeat (40) cycle();

    // leading-zero blanking
    lzb  = 1'b1;
    load = 1'b1;
    din  = 16'h0050;
    cycle();
    load = 1'b0;
    repeat (40) cycle();
    load = 1'b1;
    din  = 16'h0000;
    cycle();
    load = 1'b0;
    repeat (40) cycle();
    lzb = 1'b0;

    // last load wins, and a load on the boundary tick stays pending
    wait_pos(2);
    load = 1'b1;
    din  = 16'h1111;
    cycle();
    load = 1'b0;
    wait_pos(6);
    load = 1'b1;
    din  = 16'h2222;
    cycle();
    load = 1'b0;
    wait_pos(FRAME_LEN - 1);
    load = 1'b1;
    din  = 16'h3333;
    cycle();
    load = 1'b0;
    chk("boundary_load_pend", {15'h0, pend}, 16'h1);
    chk("boundary_frame", {15'h0, frame}, 16'h1);
    chk("boundary_nib", {12'h0, nib}, 16'h0002);
    repeat (40) cycle();

    // enable drop mid-dwell of digit 2
    wait_pos(2 * DIV + 1);
    en = 1'b0;
    cycle();
    chk("drop_an", {12'h0, an}, 16'h000F);
    chk("drop_nib", {12'h0, nib}, 16'h0000);
    repeat (FRAME_LEN) cycle();
    en = 1'b1;
    cycle();
    chk("restart_an", {12'h0, an}, 16'h000E);
    repeat (20) cycle();

    // async reset during digit 3 with a pending value
    wait_pos(3 * DIV - 1);
    load = 1'b1;
    din  = 16'h5A5A;
    cycle();
    load = 1'b0;
    chk("pre_rst_pend", {15'h0, pend}, 16'h1);
    #2 rst = 1'b1;
    #1;
    model_reset();
    chk("async_an", {12'h0, an}, 16'h000F);
    chk("async_nib", {12'h0, nib}, 16'h0000);
    chk("async_pend", {15'h0, pend}, 16'h0);
    chk("async_frame", {15'h0, frame}, 16'h0);
    cycle();
    rst = 1'b0;
    cycle();
    chk("post_rst_an", {12'h0, an}, 16'h000E);
    repeat (20) cycle();

    // random traffic
    repeat (1500) begin
      en   = ($urandom_range(0, 19) != 0);
      load = ($urandom_range(0, 9) == 0);
      din  = 16'($urandom);
      if ($urandom_range(0, 3) == 0) din[15:8] = 8'h00;
      lzb  = 1'($urandom_range(0, 1));
      rst  = ($urandom_range(0, 299) == 0);
      cycle();
    end
    rst = 1'b0;
    cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/display_scan_ctrl.md
DISPLAY_SCAN_CTRL -- requirements
Module: display_scan_ctrl

Interface
REQ-001 Parameter DIV, default 50000, SHALL set the number of clock cycles each digit is driven (dwell), legal range 2..65535.
REQ-002 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 rst  input  1  SHALL be the reset, asynchronous and active-high.
REQ-004 en  input  1  SHALL enable scanning when 1; 0 blanks the display.
REQ-005 load  input  1  SHALL request capture of din in the same cycle it is high (single-cycle strobe, level-sampled each cycle).
REQ-006 din  input  16  SHALL carry four hex nibbles; din[3:0] is digit 0 (rightmost), din[15:12] is digit 3.
REQ-007 lzb  input  1  SHALL enable leading-zero blanking when 1.
REQ-008 nib  output  4  SHALL be the nibble of the active digit, wired to the shared segment decoder inputs s3..s0 (nib[3]=s3).
REQ-009 an  output  4  SHALL be the active-low digit enables; an[k]=0 drives digit k.
REQ-010 frame  output  1  SHALL pulse high for one cycle when a digit-3 dwell completes.
REQ-011 pend  output  1  SHALL be 1 while a captured value waits for the frame boundary.

Function
REQ-012 Internal state SHALL be: state {IDLE, SCAN}, prescaler cnt (16 bit), digit index dig (2 bit), display register disp (16 bit), shadow register sh (16 bit), pend flag.
REQ-013 IDLE->SCAN SHALL occur on the first edge where en=1; SCAN->IDLE on the first edge where en=0; both transitions clear cnt and dig to 0.
REQ-014 In SCAN, cnt SHALL increment each cycle and wrap DIV-1 -> 0; tick = (cnt==DIV-1).
REQ-015 On tick, dig SHALL advance 0->1->2->3->0; each digit is therefore active exactly DIV cycles.
REQ-016 nib SHALL equal disp[4*dig+3 : 4*dig] in SCAN and 4'b0000 in IDLE.
REQ-017 an SHALL equal 4'b1111 in IDLE; in SCAN, an SHALL have only bit dig low unless that digit is blanked (then 4'b1111).
REQ-018 With lzb=1, digit k (k=1..3) SHALL be blanked when disp nibbles k..3 are all zero; digit 0 SHALL never be blanked; lzb=0 blanks nothing.
REQ-019 frame SHALL be 1 exactly in the cycle after a tick with dig==3 (registered), else 0.
REQ-020 In SCAN, load=1 SHALL write din to sh and set pend=1; disp SHALL not change until the frame boundary.
REQ-021 At a tick with dig==3 and pend=1, disp SHALL take sh and pend SHALL clear (no tearing mid-frame).
REQ-022 Multiple loads before a boundary: last load wins; earlier values are discarded.
REQ-023 Load coinciding with a boundary tick: disp takes the old sh, sh takes the new din, pend stays 1.
REQ-024 In IDLE, load=1 SHALL write din directly to both disp and sh and leave pend=0; a pending value at SCAN->IDLE SHALL be committed to disp on that transition and pend cleared.
REQ-025 en dropping mid-dwell SHALL blank (an=1111) on the next edge; no frame pulse is generated for the aborted frame.
REQ-026 All outputs SHALL be glitch-free registered-state decodes; no combinational path from din/load to an or nib.

Reset
REQ-027 While rst=1, state=IDLE, cnt=0, dig=0, disp=0, sh=0, pend=0; outputs an=4'b1111, nib=4'b0000, frame=0, pend=0.
REQ-028 rst asserted mid-operation SHALL override everything immediately (asynchronously); after release with en=1 scanning SHALL restart at digit 0 with cnt=0 on the first edge.

Verification (DIV=4)
REQ-029 Reset then en=1, load din=16'h1234 in IDLE first -> nib sequence 4,3,2,1 each held 4 cycles, an 1110,1101,1011,0111, frame pulse every 16 cycles.
REQ-030 While scanning 16'h1234, load 16'hABCD at digit 1 -> pend=1, display continues 1234 until frame pulse, then next frame shows D,C,B,A with pend=0.
REQ-031 lzb=1, disp=16'h0050 -> an: digit0 1110, digit1 1101, digits 2 and 3 1111; disp=16'h0000 -> only digit 0 lit showing 0.
REQ-032 Load 16'h1111 then 16'h2222 within one frame, then load 16'h3333 on the boundary tick -> disp=2222 next frame, pend stays 1, disp=3333 the frame after.
REQ-033 en=0 at digit 2 mid-dwell -> an=1111, nib=0, no frame pulse; en=1 again -> restarts at digit 0, cnt=0.
REQ-034 rst pulse mid-dwell of digit 3 with pend=1 -> outputs at reset values within the same cycle, disp=0, pend=0.
